// File: rtl/prod_disp_pkg.sv
// Shared types and constants for the signed-product display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with dp off.
package prod_disp_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam int DIG_W = 2;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD / minus / blank to active-low seven-segment decoder.
// dp is ORed in independently of the digit glyph.
module seg7_dec
    import prod_disp_pkg::*;
(
    input  logic [3:0] val,
    input  logic       blank,
    input  logic       minus,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] code;

    always_comb begin
        code = SEG_BLANK;
        if (minus) begin
            code = SEG_MINUS;
        end else if (!blank) begin
            case (val)
                4'd0:    code = SEG_0;
                4'd1:    code = SEG_1;
                4'd2:    code = SEG_2;
                4'd3:    code = SEG_3;
                4'd4:    code = SEG_4;
                4'd5:    code = SEG_5;
                4'd6:    code = SEG_6;
                4'd7:    code = SEG_7;
                4'd8:    code = SEG_8;
                4'd9:    code = SEG_9;
                default: code = SEG_BLANK;
            endcase
        end
        seg = {code[7] & ~dp, code[6:0]};
    end

endmodule

// File: rtl/prod_display.sv
// Latches a signed 8-bit product, converts its magnitude to BCD by sequential
// double-dabble, and multiplexes sign/hundreds/tens/units onto a 4-digit display.
module prod_display
    import prod_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] z,
    input  logic       zf,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t state_q, state_d;

    logic [7:0] mag_q;
    logic [2:0] bit_q;
    logic       sign_q, zf_q;
    logic [1:0] h_q;
    logic [3:0] t_q, u_q;
    logic [3:0] t_adj, u_adj;

    logic       disp_sign, disp_zf;
    logic [1:0] disp_h;
    logic [3:0] disp_t, disp_u;

    logic [DIV_W-1:0] div_q;
    logic [DIG_W-1:0] idx_q;

    logic [3:0] dec_val;
    logic       dec_blank, dec_minus, dec_dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CONV;
            end
            CONV:    if (bit_q == 3'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Hundreds never exceeds 2 for an 8-bit magnitude, so it needs no add-3 stage.
    always_comb begin
        t_adj = (t_q >= 4'd5) ? t_q + 4'd3 : t_q;
        u_adj = (u_q >= 4'd5) ? u_q + 4'd3 : u_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q     <= 8'd0;
            bit_q     <= 3'd0;
            sign_q    <= 1'b0;
            zf_q      <= 1'b0;
            h_q       <= 2'd0;
            t_q       <= 4'd0;
            u_q       <= 4'd0;
            disp_sign <= 1'b0;
            disp_zf   <= 1'b0;
            disp_h    <= 2'd0;
            disp_t    <= 4'd0;
            disp_u    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mag_q  <= z[7] ? (~z + 8'd1) : z;
                        sign_q <= z[7];
                        zf_q   <= zf;
                        bit_q  <= 3'd7;
                        h_q    <= 2'd0;
                        t_q    <= 4'd0;
                        u_q    <= 4'd0;
                    end
                end
                CONV: begin
                    h_q   <= h_q + h_q + {1'b0, t_adj[3]};
                    t_q   <= {t_adj[2:0], u_adj[3]};
                    u_q   <= {u_adj[2:0], mag_q[bit_q]};
                    bit_q <= bit_q - 3'd1;
                end
                DONE: begin
                    disp_sign <= sign_q;
                    disp_zf   <= zf_q;
                    disp_h    <= h_q;
                    disp_t    <= t_q;
                    disp_u    <= u_q;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan; conversion activity never disturbs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= idx_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_comb begin
        an        = ~(4'b0001 << idx_q);
        dec_val   = 4'd0;
        dec_blank = 1'b1;
        dec_minus = 1'b0;
        dec_dp    = 1'b0;
        unique case (idx_q)
            2'd3: dec_minus = disp_sign;
            2'd2: begin
                dec_val   = {2'b00, disp_h};
                dec_blank = (disp_h == 2'd0);
            end
            2'd1: begin
                dec_val   = disp_t;
                dec_blank = (disp_h == 2'd0) && (disp_t == 4'd0);
            end
            2'd0: begin
                dec_val   = disp_u;
                dec_blank = 1'b0;
                dec_dp    = disp_zf;
            end
        endcase
    end

    seg7_dec u_dec (
        .val   (dec_val),
        .blank (dec_blank),
        .minus (dec_minus),
        .dp    (dec_dp),
        .seg   (seg)
    );

endmodule
